// File: rtl/reg_write_back_pkg.sv
// rtl/reg_write_back_pkg.sv - shared state enum, address map and widths for reg_write_back
package reg_write_back_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;
  localparam int NUM_WE = 35;

  localparam logic [ADDR_W-1:0] REG_LAST = 6'd27;
  localparam logic [ADDR_W-1:0] PI0      = 6'd28;
  localparam logic [ADDR_W-1:0] PI1      = 6'd29;
  localparam logic [ADDR_W-1:0] PO0      = 6'd30;
  localparam logic [ADDR_W-1:0] PO1      = 6'd31;
  localparam logic [ADDR_W-1:0] R32      = 6'd32;
  localparam logic [ADDR_W-1:0] R33      = 6'd33;
  localparam logic [ADDR_W-1:0] WREG     = 6'd34;

  typedef enum logic [1:0] {
    IDLE,
    COMMIT,
    NOTIFY
  } wb_state_t;

endpackage

// File: rtl/wb_addr_decode.sv
// rtl/wb_addr_decode.sv - destination address to one-hot write enable plus invalid flag
// OUTPUT_PORTS_EN makes addresses 30 and 31 writable.
module wb_addr_decode
  import reg_write_back_pkg::*;
(
  input  logic [ADDR_W-1:0] i_sel,
  output logic [NUM_WE-1:0] o_we,
  output logic              o_invalid
);

  logic w_ok;

  always_comb begin
    w_ok = (i_sel <= REG_LAST) || (i_sel == R32) || (i_sel == R33) || (i_sel == WREG);
`ifdef OUTPUT_PORTS_EN
    w_ok = w_ok || (i_sel == PO0) || (i_sel == PO1);
`endif
    o_we      = w_ok ? (NUM_WE'(1) << i_sel) : '0;
    o_invalid = !w_ok;
  end

endmodule

// File: rtl/reg_write_back.sv
// rtl/reg_write_back.sv - write-back register file with IDLE/COMMIT/NOTIFY handshake
// OUTPUT_PORTS_EN adds Output_Port_0/1 at addresses 30/31.
module reg_write_back
  import reg_write_back_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] Sel_C,
  input  logic [DATA_W-1:0] Data_C,
  output logic [DATA_W-1:0] r0,  r1,  r2,  r3,  r4,  r5,  r6,  r7,
  output logic [DATA_W-1:0] r8,  r9,  r10, r11, r12, r13, r14, r15,
  output logic [DATA_W-1:0] r16, r17, r18, r19, r20, r21, r22, r23,
  output logic [DATA_W-1:0] r24, r25, r26, r27,
  output logic [DATA_W-1:0] r32,
  output logic [DATA_W-1:0] r33,
  output logic [DATA_W-1:0] Working_Register,
`ifdef OUTPUT_PORTS_EN
  output logic [DATA_W-1:0] Output_Port_0,
  output logic [DATA_W-1:0] Output_Port_1,
`endif
  output logic              updateBlock,
  output logic              err_invalid
);

  localparam int NGPR = int'(REG_LAST) + 1;

  wb_state_t         r_state;
  logic [ADDR_W-1:0] r_sel;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_gpr [0:NGPR-1];
  logic [DATA_W-1:0] r_r32, r_r33, r_wreg;
  logic              r_upd;
  logic [NUM_WE-1:0] w_we;
  logic              w_invalid;
  logic              w_accept;
`ifdef OUTPUT_PORTS_EN
  logic [DATA_W-1:0] r_po0, r_po1;
  wire               w_unused = &{1'b0, w_we[PI1:PI0]};
`else
  wire               w_unused = &{1'b0, w_we[PO1:PI0]};
`endif

  // Decode the held address, so changes on Sel_C after accept cannot disturb COMMIT.
  wb_addr_decode u_dec (
    .i_sel     (r_sel),
    .o_we      (w_we),
    .o_invalid (w_invalid)
  );

  assign wr_ready    = ((r_state == IDLE) || (r_state == NOTIFY)) && !reset;
  assign w_accept    = wr_valid && wr_ready;
  assign updateBlock = r_upd && !reset;
  assign err_invalid = (r_state == COMMIT) && w_invalid && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_data  <= '0;
      r_upd   <= 1'b0;
      for (int i = 0; i < NGPR; i++) r_gpr[i] <= '0;
      r_r32   <= '0;
      r_r33   <= '0;
      r_wreg  <= '0;
`ifdef OUTPUT_PORTS_EN
      r_po0   <= '0;
      r_po1   <= '0;
`endif
    end else begin
      r_upd <= 1'b0;
      if (w_accept) begin
        r_sel  <= Sel_C;
        r_data <= Data_C;
      end
      case (r_state)
        IDLE:   r_state <= w_accept ? COMMIT : IDLE;
        COMMIT: begin
          if (w_invalid) begin
            r_state <= IDLE;
          end else begin
            for (int i = 0; i < NGPR; i++) if (w_we[i]) r_gpr[i] <= r_data;
            if (w_we[R32])  r_r32  <= r_data;
            if (w_we[R33])  r_r33  <= r_data;
            if (w_we[WREG]) r_wreg <= r_data;
`ifdef OUTPUT_PORTS_EN
            if (w_we[PO0])  r_po0  <= r_data;
            if (w_we[PO1])  r_po1  <= r_data;
`endif
            r_upd   <= 1'b1;
            r_state <= NOTIFY;
          end
        end
        NOTIFY: r_state <= w_accept ? COMMIT : IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign r0  = r_gpr[0];  assign r1  = r_gpr[1];  assign r2  = r_gpr[2];  assign r3  = r_gpr[3];
  assign r4  = r_gpr[4];  assign r5  = r_gpr[5];  assign r6  = r_gpr[6];  assign r7  = r_gpr[7];
  assign r8  = r_gpr[8];  assign r9  = r_gpr[9];  assign r10 = r_gpr[10]; assign r11 = r_gpr[11];
  assign r12 = r_gpr[12]; assign r13 = r_gpr[13]; assign r14 = r_gpr[14]; assign r15 = r_gpr[15];
  assign r16 = r_gpr[16]; assign r17 = r_gpr[17]; assign r18 = r_gpr[18]; assign r19 = r_gpr[19];
  assign r20 = r_gpr[20]; assign r21 = r_gpr[21]; assign r22 = r_gpr[22]; assign r23 = r_gpr[23];
  assign r24 = r_gpr[24]; assign r25 = r_gpr[25]; assign r26 = r_gpr[26]; assign r27 = r_gpr[27];
  assign r32 = r_r32;
  assign r33 = r_r33;
  assign Working_Register = r_wreg;
`ifdef OUTPUT_PORTS_EN
  assign Output_Port_0 = r_po0;
  assign Output_Port_1 = r_po1;
`endif

endmodule
